hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk input 1 system clock; rst_n input 1 synchronous active-low reset, sampled on rising clk edge.
REQ-002 SHALL have inputs IFID_RS1, IFID_RS2 (5 each): source registers of the instruction in ID.
REQ-003 SHALL have inputs IDEX_RD (5), IDEX_MemRead (1), IDEX_RegWrite (1): destination register, load flag and write flag of the instruction in EX.
REQ-004 SHALL have input IFID_Branch (1): the instruction in ID is a branch or jalr that is resolved in ID.
REQ-005 SHALL have input BranchTaken (1): ID resolved a redirect this cycle.
REQ-006 SHALL have inputs ICACHE_stall and DCACHE_stall (1 each): a memory is busy.
REQ-007 SHALL have outputs PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush and Freeze (1 each).
REQ-008 SHALL have output state (2): current FSM state, for debug.

Function
REQ-009 SHALL define hazard LU = IDEX_MemRead & (IDEX_RD != 0) & (IDEX_RD == IFID_RS1 | IDEX_RD == IFID_RS2).
REQ-010 SHALL define hazard BA = IFID_Branch & IDEX_RegWrite & ~IDEX_MemRead & (IDEX_RD != 0) & (IDEX_RD == IFID_RS1 | IDEX_RD == IFID_RS2).
REQ-011 SHALL define hazard BL = LU & IFID_Branch.
REQ-012 SHALL implement FSM states RUN=0, STALL_B=1, FREEZE=2; encoding 3 is unused and SHALL return to RUN on the next edge.
REQ-013 SHALL drive all outputs combinationally from state and inputs (zero-cycle latency); only the state and resume registers SHALL be clocked.
REQ-014 Priority, highest first: memory stall (ICACHE_stall|DCACHE_stall), then the STALL_B forced stall, then LU/BA, then BranchTaken.
REQ-015 RUN with a memory stall: Freeze=1, PC_Write=0, IFID_Write=0, IDEX_Bubble=0, IFID_Flush=0; resume register <= RUN; next state FREEZE.
REQ-016 RUN with LU or BA: PC_Write=0, IFID_Write=0, IDEX_Bubble=1; next state is STALL_B if BL, else RUN.
REQ-017 RUN with no hazard: PC_Write=1, IFID_Write=1, IDEX_Bubble=0; IFID_Flush=BranchTaken.
REQ-018 STALL_B with no memory stall: PC_Write=0, IFID_Write=0, IDEX_Bubble=1; BranchTaken ignored; next state RUN.
REQ-019 STALL_B with a memory stall: freeze outputs as in REQ-015; resume register <= STALL_B; next state FREEZE.
REQ-020 FREEZE: Freeze=1, PC_Write=0, IFID_Write=0, IDEX_Bubble=0, IFID_Flush=0 for every cycle a memory stall is high.
REQ-021 FREEZE with the memory stall low: outputs evaluated as in the resume state in that same cycle; next state is that state's successor.
REQ-022 IFID_Flush SHALL never be high in the same cycle as PC_Write=0.
REQ-023 A hazard with register x0 SHALL never stall.

Reset
REQ-024 While rst_n is low at a clock edge: state <= RUN and resume <= RUN.
REQ-025 In the cycle after reset: PC_Write=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0, Freeze=0, state=0, given no hazard inputs.
REQ-026 Reset asserted in STALL_B or FREEZE SHALL abandon the pending stall; no extra bubble after reset.

Configuration
REQ-027 Macro HAZARD_PERF_CNT_EN defined adds output stall_cycles (32) and output flush_count (16).
REQ-028 With the macro defined, stall_cycles SHALL increment on every cycle where PC_Write=0.
REQ-029 With the macro defined, flush_count SHALL increment on every IFID_Flush=1.
REQ-030 Both counters SHALL wrap modulo 2^n and SHALL reset to 0.
REQ-031 Without the macro, neither port nor any counter logic SHALL exist; all other behaviour is identical.

Verification
REQ-032 Load-use: IDEX_MemRead=1, IDEX_RD=5, IFID_RS2=5, IFID_Branch=0 -> one cycle with PC_Write=0 and IDEX_Bubble=1, then RUN.
REQ-033 Branch on load: as REQ-032 with IFID_Branch=1 -> two consecutive bubble cycles, state sequence 0,1,0; BranchTaken=1 in cycle 2 gives IFID_Flush=0.
REQ-034 Branch on ALU result: IDEX_RegWrite=1, IDEX_RD=7, IFID_RS1=7, IFID_Branch=1 -> exactly one bubble cycle; IDEX_RD=0 with IFID_RS1=0 gives no stall.
REQ-035 DCACHE_stall=1 for 3 cycles arriving in STALL_B -> Freeze=1 for 3 cycles, then one STALL_B bubble, then RUN.
REQ-036 Reset mid-FREEZE -> next cycle state=0 and PC_Write=1.
REQ-037 With HAZARD_PERF_CNT_EN defined, preload stall_cycles=0xFFFFFFFF, then one stall cycle -> stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage core with branches resolved in ID.
//
// Detects load-use (LU), branch-on-ALU-result (BA) and branch-on-load (BL) hazards.
// Also freezes the whole pipeline while either cache reports busy.
// All control outputs are combinational from the current state and inputs.
// Only the FSM state and the resume register are clocked.
//
// Ports:
//   clk, rst_n           system clock, synchronous active-low reset
//   IFID_RS1/RS2         source registers of the instruction in ID
//   IDEX_RD              destination register of the instruction in EX
//   IDEX_MemRead         instruction in EX is a load
//   IDEX_RegWrite        instruction in EX writes a register
//   IFID_Branch          instruction in ID is a branch/jalr resolved in ID
//   BranchTaken          ID resolved a redirect this cycle
//   ICACHE/DCACHE_stall  a memory is busy
//   PC_Write, IFID_Write enables for the PC and the IF/ID register
//   IDEX_Bubble          insert a NOP into ID/EX
//   IFID_Flush           squash the instruction in IF/ID
//   Freeze               whole-pipeline hold during a memory stall
//   state                current FSM state (0 RUN, 1 STALL_B, 2 FREEZE), debug only
//
// Optional build macro HAZARD_PERF_CNT_EN adds two performance counter outputs:
//   stall_cycles (32)    cycles with PC_Write low
//   flush_count  (16)    cycles with IFID_Flush high
// Both counters wrap and reset to 0.

module hazard_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] IFID_RS1,
    input  logic [4:0] IFID_RS2,
    input  logic [4:0] IDEX_RD,
    input  logic       IDEX_MemRead,
    input  logic       IDEX_RegWrite,
    input  logic       IFID_Branch,
    input  logic       BranchTaken,
    input  logic       ICACHE_stall,
    input  logic       DCACHE_stall,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IDEX_Bubble,
    output logic       IFID_Flush,
    output logic       Freeze,
    output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StStallB = 2'd1,
        StFreeze = 2'd2,
        StRsvd   = 2'd3
    } state_e;

    state_e state_q, state_d;
    state_e resume_q, resume_d;
    state_e eff_state;

    logic rd_match;
    logic haz_lu;
    logic haz_ba;
    logic haz_bl;
    logic mem_stall;

    // x0 never creates a dependency, so it never stalls.
    assign rd_match  = (IDEX_RD != 5'd0) &&
                       ((IDEX_RD == IFID_RS1) || (IDEX_RD == IFID_RS2));
    assign haz_lu    = IDEX_MemRead && rd_match;
    assign haz_ba    = IFID_Branch && IDEX_RegWrite && !IDEX_MemRead && rd_match;
    assign haz_bl    = haz_lu && IFID_Branch;
    assign mem_stall = ICACHE_stall || DCACHE_stall;

    // State whose rules apply this cycle when no memory stall is present.
    // FREEZE behaves as the state it interrupted; the unused code acts as RUN.
    always_comb begin
        unique case (state_q)
            StFreeze: eff_state = resume_q;
            StStallB: eff_state = StStallB;
            default:  eff_state = StRun;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StRun;
            resume_q <= StRun;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        if (state_q == StRsvd) begin
            state_d  = StRun;
            resume_d = StRun;
        end else if (mem_stall) begin
            state_d = StFreeze;
            // Only capture on entry; while frozen keep the interrupted state.
            if (state_q != StFreeze) begin
                resume_d = eff_state;
            end
        end else begin
            unique case (eff_state)
                StStallB: state_d = StRun;
                default:  state_d = haz_bl ? StStallB : StRun;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        Freeze      = 1'b0;
        if (mem_stall) begin
            Freeze = 1'b1;
        end else if (eff_state == StStallB) begin
            // Second bubble of a branch-on-load; the redirect is not yet trustworthy.
            IDEX_Bubble = 1'b1;
        end else if (haz_lu || haz_ba) begin
            IDEX_Bubble = 1'b1;
        end else begin
            PC_Write   = 1'b1;
            IFID_Write = 1'b1;
            IFID_Flush = BranchTaken;
        end
    end

    assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 16'd0;
        end else begin
            if (!PC_Write) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (IFID_Flush) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
